// File: rtl/udma_pkg.sv
// Shared uDMA definitions: channel destination type and camera register offsets.
// camera_if reuses the offsets, so they live here rather than in the register file.
package udma_pkg;

  localparam int DEST_SIZE = 2;
  typedef logic [DEST_SIZE-1:0] ch_dest_t;

  localparam logic [4:0] REG_RX_SADDR      = 5'h00;
  localparam logic [4:0] REG_RX_SIZE       = 5'h01;
  localparam logic [4:0] REG_RX_CFG        = 5'h02;
  localparam logic [4:0] REG_RX_DEST       = 5'h03;
  localparam logic [4:0] REG_CAM_CFG_GLOB  = 5'h08;
  localparam logic [4:0] REG_CAM_CFG_LL    = 5'h09;
  localparam logic [4:0] REG_CAM_CFG_UR    = 5'h0A;
  localparam logic [4:0] REG_CAM_CFG_SIZE  = 5'h0B;
  localparam logic [4:0] REG_CAM_CFG_FILT  = 5'h0C;
  localparam logic [4:0] REG_CAM_VSYNC_POL = 5'h0D;

  // Reset element size is 32-bit words.
  localparam logic [1:0] RX_DATASIZE_RST = 2'b10;

endpackage

// File: rtl/camera_cfg_regfile_if.sv
// uDMA peripheral config bus: single-cycle word-addressed read/write access.
interface camera_cfg_bus_if;

  logic [31:0] cfg_data_i;
  logic [4:0]  cfg_addr_i;
  logic        cfg_valid_i;
  logic        cfg_rwn_i;
  logic [31:0] cfg_data_o;
  logic        cfg_ready_o;

  modport master (
    output cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
    input  cfg_data_o, cfg_ready_o
  );

  modport slave (
    input  cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
    output cfg_data_o, cfg_ready_o
  );

endinterface

// File: rtl/camera_cfg_regfile.sv
// Camera (CPI) uDMA config/status register file: RX channel setup, camera
// datapath config words, and live RX status readback.
module camera_cfg_regfile
  import udma_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  camera_cfg_bus_if.slave           cfg,

  output logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o,
  output logic [TRANS_SIZE-1:0]     cfg_rx_size_o,
  output logic [1:0]                cfg_rx_datasize_o,
  output logic                      cfg_rx_continuous_o,
  output logic                      cfg_rx_en_o,
  output logic                      cfg_rx_clr_o,
  input  logic                      cfg_rx_en_i,
  input  logic                      cfg_rx_pending_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_rx_curr_addr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_rx_bytes_left_i,
  output ch_dest_t                  cfg_rx_dest_o,

  input  logic                      cfg_cam_ip_en_i,
  output logic                      cfg_cam_vsync_polarity_o,
  output logic [31:0]               cfg_cam_cfg_o,
  output logic [31:0]               cfg_cam_cfg_ll_o,
  output logic [31:0]               cfg_cam_cfg_ur_o,
  output logic [31:0]               cfg_cam_cfg_size_o,
  output logic [31:0]               cfg_cam_cfg_filter_o
);

  logic we, re, cam_we;

  assign we     = cfg.cfg_valid_i & ~cfg.cfg_rwn_i;
  assign re     = cfg.cfg_valid_i &  cfg.cfg_rwn_i;
  // Datapath config must not change under a running capture.
  assign cam_we = we & ~cfg_cam_ip_en_i;

  assign cfg.cfg_ready_o = 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_rx_startaddr_o       <= '0;
      cfg_rx_size_o            <= '0;
      cfg_rx_datasize_o        <= RX_DATASIZE_RST;
      cfg_rx_continuous_o      <= 1'b0;
      cfg_rx_en_o              <= 1'b0;
      cfg_rx_clr_o             <= 1'b0;
      cfg_rx_dest_o            <= '0;
      cfg_cam_vsync_polarity_o <= 1'b0;
      cfg_cam_cfg_o            <= '0;
      cfg_cam_cfg_ll_o         <= '0;
      cfg_cam_cfg_ur_o         <= '0;
      cfg_cam_cfg_size_o       <= '0;
      cfg_cam_cfg_filter_o     <= '0;
    end else begin
      cfg_rx_en_o  <= 1'b0;
      cfg_rx_clr_o <= 1'b0;
      if (we) begin
        unique case (cfg.cfg_addr_i)
          REG_RX_SADDR:      cfg_rx_startaddr_o <= cfg.cfg_data_i[L2_AWIDTH_NOAL-1:0];
          REG_RX_SIZE:       cfg_rx_size_o      <= cfg.cfg_data_i[TRANS_SIZE-1:0];
          REG_RX_CFG: begin
            cfg_rx_continuous_o <= cfg.cfg_data_i[0];
            cfg_rx_datasize_o   <= cfg.cfg_data_i[2:1];
            cfg_rx_en_o         <= cfg.cfg_data_i[4];
            cfg_rx_clr_o        <= cfg.cfg_data_i[6];
          end
          REG_RX_DEST:       cfg_rx_dest_o            <= cfg.cfg_data_i[DEST_SIZE-1:0];
          REG_CAM_VSYNC_POL: cfg_cam_vsync_polarity_o <= cfg.cfg_data_i[0];
          default: ;
        endcase
      end
      if (cam_we) begin
        unique case (cfg.cfg_addr_i)
          REG_CAM_CFG_GLOB: cfg_cam_cfg_o        <= cfg.cfg_data_i;
          REG_CAM_CFG_LL:   cfg_cam_cfg_ll_o     <= cfg.cfg_data_i;
          REG_CAM_CFG_UR:   cfg_cam_cfg_ur_o     <= cfg.cfg_data_i;
          REG_CAM_CFG_SIZE: cfg_cam_cfg_size_o   <= cfg.cfg_data_i;
          REG_CAM_CFG_FILT: cfg_cam_cfg_filter_o <= cfg.cfg_data_i;
          default: ;
        endcase
      end
    end
  end

  // Address/status readback is live: RX_SADDR/RX_SIZE reflect channel progress.
  always_comb begin
    cfg.cfg_data_o = '0;
    if (re) begin
      unique case (cfg.cfg_addr_i)
        REG_RX_SADDR:      cfg.cfg_data_o = 32'(cfg_rx_curr_addr_i);
        REG_RX_SIZE:       cfg.cfg_data_o = 32'(cfg_rx_bytes_left_i);
        REG_RX_CFG:        cfg.cfg_data_o = {26'h0, cfg_rx_pending_i, cfg_rx_en_i, 1'b0,
                                             cfg_rx_datasize_o, cfg_rx_continuous_o};
        REG_RX_DEST:       cfg.cfg_data_o = 32'(cfg_rx_dest_o);
        REG_CAM_CFG_GLOB:  cfg.cfg_data_o = cfg_cam_cfg_o;
        REG_CAM_CFG_LL:    cfg.cfg_data_o = cfg_cam_cfg_ll_o;
        REG_CAM_CFG_UR:    cfg.cfg_data_o = cfg_cam_cfg_ur_o;
        REG_CAM_CFG_SIZE:  cfg.cfg_data_o = cfg_cam_cfg_size_o;
        REG_CAM_CFG_FILT:  cfg.cfg_data_o = cfg_cam_cfg_filter_o;
        REG_CAM_VSYNC_POL: cfg.cfg_data_o = {31'h0, cfg_cam_vsync_polarity_o};
        default:           cfg.cfg_data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_cfg_regfile.sv
// Directed bench for camera_cfg_regfile: expectations queued at drive time, popped at sample time.
module tb_camera_cfg_regfile;
  import udma_pkg::*;

  localparam int AW = 12;
  localparam int TS = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_en_i = 1'b0, rx_pending_i = 1'b0, ip_en = 1'b0;
  logic [AW-1:0] curr_addr = '0;
  logic [TS-1:0] bytes_left = '0;

  logic [AW-1:0] startaddr;
  logic [TS-1:0] rxsize;
  logic [1:0]    datasize;
  logic          continuous, en_o, clr_o, vsync;
  ch_dest_t      dest;
  logic [31:0]   glob, ll, ur, csize, filt;

  camera_cfg_bus_if bus();

  camera_cfg_regfile #(.L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS)) dut (
    .clk_i(clk), .rst_i(rst), .cfg(bus),
    .cfg_rx_startaddr_o(startaddr), .cfg_rx_size_o(rxsize),
    .cfg_rx_datasize_o(datasize), .cfg_rx_continuous_o(continuous),
    .cfg_rx_en_o(en_o), .cfg_rx_clr_o(clr_o),
    .cfg_rx_en_i(rx_en_i), .cfg_rx_pending_i(rx_pending_i),
    .cfg_rx_curr_addr_i(curr_addr), .cfg_rx_bytes_left_i(bytes_left),
    .cfg_rx_dest_o(dest), .cfg_cam_ip_en_i(ip_en),
    .cfg_cam_vsync_polarity_o(vsync), .cfg_cam_cfg_o(glob),
    .cfg_cam_cfg_ll_o(ll), .cfg_cam_cfg_ur_o(ur),
    .cfg_cam_cfg_size_o(csize), .cfg_cam_cfg_filter_o(filt)
  );

  always #5 clk = ~clk;

  typedef struct { string tag; logic [31:0] exp; } exp_t;
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h required=<queued expectation>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%h required=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cfg_addr_i = a; bus.cfg_data_i = d;
    bus.cfg_rwn_i = 1'b0; bus.cfg_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.cfg_valid_i = 1'b0;
  endtask

  // Queues the expected read data, then samples the combinational response.
  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    @(negedge clk);
    bus.cfg_addr_i = a; bus.cfg_rwn_i = 1'b1; bus.cfg_valid_i = 1'b1;
    push(tag, exp);
    #1 chk(bus.cfg_data_o);
    n_chk++;
    assert (bus.cfg_ready_o === 1'b1) else begin
      n_fail++;
      $error("FAIL ready observed=%b required=1", bus.cfg_ready_o);
    end
    bus.cfg_valid_i = 1'b0; bus.cfg_rwn_i = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    bus.cfg_data_i = '0; bus.cfg_addr_i = '0;
    bus.cfg_valid_i = 1'b0; bus.cfg_rwn_i = 1'b0;

    // reset asserted mid-cycle, checked before any clock edge
    #13 rst = 1'b1;
    push("rst_startaddr", 32'h0); push("rst_size", 32'h0); push("rst_datasize", 32'h2);
    push("rst_cont", 32'h0); push("rst_en", 32'h0); push("rst_clr", 32'h0);
    push("rst_glob", 32'h0); push("rst_dest", 32'h0); push("rst_vsync", 32'h0);
    push("rst_rdata_idle", 32'h0);
    #1;
    chk(32'(startaddr)); chk(32'(rxsize)); chk(32'(datasize)); chk(32'(continuous));
    chk(32'(en_o)); chk(32'(clr_o)); chk(glob); chk(32'(dest)); chk(32'(vsync));
    chk(bus.cfg_data_o);
    @(negedge clk); rst = 1'b0;
    rd("rst_rd_rxcfg", REG_RX_CFG, 32'h4);

    // RX setup with enable pulse
    wr(REG_RX_SADDR, 32'h123);
    wr(REG_RX_SIZE, 32'h0400);
    wr(REG_RX_CFG, 32'h15);
    push("en_pulse_hi", 32'h1); push("clr_while_en", 32'h0);
    push("cont_set", 32'h1); push("datasize_set", 32'h2);
    chk(32'(en_o)); chk(32'(clr_o)); chk(32'(continuous)); chk(32'(datasize));
    push("startaddr", 32'h123); push("size", 32'h400);
    chk(32'(startaddr)); chk(32'(rxsize));
    idle();
    push("en_pulse_lo", 32'h0); push("clr_still_lo", 32'h0);
    chk(32'(en_o)); chk(32'(clr_o));

    // clear pulse only; keep datasize=2, continuous=0
    wr(REG_RX_CFG, 32'h44);
    push("clr_pulse_hi", 32'h1); push("en_with_clr", 32'h0);
    chk(32'(clr_o)); chk(32'(en_o));
    idle();
    push("clr_pulse_lo", 32'h0);
    chk(32'(clr_o));
    rx_pending_i = 1'b1; rx_en_i = 1'b1;
    rd("rd_rxcfg_status", REG_RX_CFG, 32'h34);
    rx_pending_i = 1'b0; rx_en_i = 1'b0;

    wr(REG_RX_DEST, 32'hFFFF_FFFF);
    rd("rd_dest", REG_RX_DEST, 32'(ch_dest_t'('1)));

    // camera datapath words
    wr(REG_CAM_CFG_GLOB, 32'h8000_0F81);
    wr(REG_CAM_CFG_LL,   32'h0002_0001);
    wr(REG_CAM_CFG_FILT, 32'h0040_8020);
    push("glob", 32'h8000_0F81); push("ll", 32'h0002_0001); push("filt", 32'h0040_8020);
    chk(glob); chk(ll); chk(filt);
    rd("rd_glob", REG_CAM_CFG_GLOB, 32'h8000_0F81);
    rd("rd_ll",   REG_CAM_CFG_LL,   32'h0002_0001);
    rd("rd_filt", REG_CAM_CFG_FILT, 32'h0040_8020);

    // lock blocks camera words only
    ip_en = 1'b1;
    wr(REG_CAM_CFG_GLOB, 32'h0);
    wr(REG_CAM_CFG_FILT, 32'h0);
    wr(REG_CAM_VSYNC_POL, 32'h1);
    wr(REG_RX_SADDR, 32'h456);
    push("glob_locked", 32'h8000_0F81); push("filt_locked", 32'h0040_8020);
    push("vsync_unlocked", 32'h1); push("saddr_unlocked", 32'h456);
    chk(glob); chk(filt); chk(32'(vsync)); chk(32'(startaddr));
    rd("rd_glob_locked", REG_CAM_CFG_GLOB, 32'h8000_0F81);
    ip_en = 1'b0;
    wr(REG_CAM_CFG_GLOB, 32'h0);
    push("glob_unlocked", 32'h0);
    chk(glob);

    // live status reads and unmapped address
    curr_addr = 12'hABC; bytes_left = 16'h1234;
    rd("rd_curr_addr", REG_RX_SADDR, 32'h0000_0ABC);
    rd("rd_bytes_left", REG_RX_SIZE, 32'h0000_1234);
    rd("rd_unmapped", 5'h1F, 32'h0);
    wr(5'h1F, 32'hFFFF_FFFF);
    push("unm_glob", 32'h0); push("unm_saddr", 32'h456); push("unm_size", 32'h400);
    push("unm_ll", 32'h0002_0001); push("unm_en", 32'h0); push("unm_clr", 32'h0);
    chk(glob); chk(32'(startaddr)); chk(32'(rxsize)); chk(ll); chk(32'(en_o)); chk(32'(clr_o));

    // reset during a live pulse kills it immediately
    wr(REG_RX_CFG, 32'h50);
    push("pre_rst_en", 32'h1);
    chk(32'(en_o));
    #2 rst = 1'b1;
    push("rst_kills_en", 32'h0); push("rst_kills_clr", 32'h0);
    push("rst_ds_again", 32'h2); push("rst_ll_again", 32'h0);
    #1;
    chk(32'(en_o)); chk(32'(clr_o)); chk(32'(datasize)); chk(ll);
    @(negedge clk); rst = 1'b0;

    n_chk++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
